// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, a single-entry
// hand-off register to decode, and redirect handling that squashes stale responses.
//
// state  | meaning
// S_REQ  | presenting pc to imem, waiting for the request handshake
// S_WAIT | request accepted, waiting for the one-cycle response pulse
// S_OUT  | fetched word held on the decode interface until accepted
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_drop;
    logic        w_drop_nxt;
    logic        r_id_valid;
    logic        w_id_valid_nxt;
    logic [31:0] r_id_pc;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] r_id_instr;
    logic [31:0] w_id_instr_nxt;

    logic [31:0] w_redirect_target;
    logic        w_req_fire;

    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_req_fire        = imem_req_valid && imem_req_ready;

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign id_valid       = r_id_valid;
    assign id_pc          = r_id_pc;
    assign id_pc_plus4    = r_id_pc + 32'd4;
    assign id_instr       = r_id_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_instr <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_instr <= w_id_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_id_valid_nxt = r_id_valid;
        w_id_pc_nxt    = r_id_pc;
        w_id_instr_nxt = r_id_instr;

        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_target;
                    if (w_req_fire) begin
                        // Request for the old pc is already in flight; squash its response.
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end else if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_target;
                    if (imem_rsp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_id_instr_nxt = imem_rsp_data;
                        w_id_pc_nxt    = r_pc;
                        w_id_valid_nxt = 1'b1;
                        w_state_nxt    = S_OUT;
                    end
                end
            end

            S_OUT: begin
                if (redirect_valid) begin
                    w_pc_nxt       = w_redirect_target;
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end else if (id_ready) begin
                    w_pc_nxt       = r_pc + 32'd4;
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table covering reset,
// stall, redirects and pc wrap, plus a free-running memory sequence for throughput.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdv;
        logic [31:0] rdpc;
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        id_rdy;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_idpc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [37];

    function automatic vec_t mk(logic r, logic rdv, logic [31:0] rdpc, logic rq_rdy,
                                logic rsp_v, logic [31:0] rsp_d, logic id_rdy,
                                logic e_req_v, logic [31:0] e_addr, logic e_idv,
                                logic [31:0] e_idpc, logic [31:0] e_instr);
        vec_t v;
        v.rst = r;         v.rdv = rdv;       v.rdpc = rdpc;
        v.rq_rdy = rq_rdy; v.rsp_v = rsp_v;   v.rsp_d = rsp_d;
        v.id_rdy = id_rdy; v.e_req_v = e_req_v; v.e_addr = e_addr;
        v.e_idv = e_idv;   v.e_idpc = e_idpc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    logic        pending;
    logic [31:0] pend_data;
    int          nseen;

    initial begin
        // rst rdv rdpc  rdy rspv rspd  idr | req addr idv idpc instr
        tbl[0]  = mk(1,0,32'h0,1,0,32'h0,1,            0,32'h0,0,32'h0,NOP);
        tbl[1]  = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h0,0,32'h0,NOP);
        tbl[2]  = mk(0,0,32'h0,1,1,32'h1111_1111,1,    0,32'h0,0,32'h0,NOP);
        tbl[3]  = mk(0,0,32'h0,1,0,32'h0,1,            0,32'h0,1,32'h0,32'h1111_1111);
        tbl[4]  = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h4,0,32'h0,32'h1111_1111);
        tbl[5]  = mk(0,0,32'h0,1,1,32'h2222_2222,1,    0,32'h4,0,32'h0,32'h1111_1111);
        tbl[6]  = mk(0,0,32'h0,1,0,32'h0,1,            0,32'h4,1,32'h4,32'h2222_2222);
        tbl[7]  = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h8,0,32'h4,32'h2222_2222);
        tbl[8]  = mk(0,0,32'h0,1,1,32'h0050_0093,1,    0,32'h8,0,32'h4,32'h2222_2222);
        tbl[9]  = mk(0,0,32'h0,1,0,32'h0,0,            0,32'h8,1,32'h8,32'h0050_0093);
        tbl[10] = mk(0,0,32'h0,1,1,32'hFFFF_FFFF,0,    0,32'h8,1,32'h8,32'h0050_0093);
        tbl[11] = mk(0,0,32'h0,1,0,32'h0,0,            0,32'h8,1,32'h8,32'h0050_0093);
        tbl[12] = mk(0,0,32'h0,1,0,32'h0,0,            0,32'h8,1,32'h8,32'h0050_0093);
        tbl[13] = mk(0,0,32'h0,1,0,32'h0,0,            0,32'h8,1,32'h8,32'h0050_0093);
        tbl[14] = mk(0,0,32'h0,1,0,32'h0,1,            0,32'h8,1,32'h8,32'h0050_0093);
        tbl[15] = mk(0,0,32'h0,0,1,32'hFFFF_FFFF,1,    1,32'hC,0,32'h8,32'h0050_0093);
        tbl[16] = mk(0,0,32'h0,1,0,32'h0,1,            1,32'hC,0,32'h8,32'h0050_0093);
        tbl[17] = mk(0,1,32'h103,1,0,32'h0,1,          0,32'hC,0,32'h8,32'h0050_0093);
        tbl[18] = mk(0,0,32'h0,1,0,32'h0,1,            0,32'h100,0,32'h8,32'h0050_0093);
        tbl[19] = mk(0,0,32'h0,1,1,32'hDEAD_BEEF,1,    0,32'h100,0,32'h8,32'h0050_0093);
        tbl[20] = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h100,0,32'h8,32'h0050_0093);
        tbl[21] = mk(0,0,32'h0,1,1,32'h3333_3333,1,    0,32'h100,0,32'h8,32'h0050_0093);
        tbl[22] = mk(0,0,32'h0,1,0,32'h0,1,            0,32'h100,1,32'h100,32'h3333_3333);
        tbl[23] = mk(0,1,32'h40,0,0,32'h0,1,           1,32'h104,0,32'h100,32'h3333_3333);
        tbl[24] = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h40,0,32'h100,32'h3333_3333);
        tbl[25] = mk(0,0,32'h0,1,1,32'h4444_4444,1,    0,32'h40,0,32'h100,32'h3333_3333);
        tbl[26] = mk(0,1,32'h200,1,0,32'h0,1,          0,32'h40,1,32'h40,32'h4444_4444);
        tbl[27] = mk(0,1,32'hFFFF_FFFC,1,0,32'h0,1,    1,32'h200,0,32'h40,32'h4444_4444);
        tbl[28] = mk(0,0,32'h0,1,1,32'h5555_5555,1,    0,32'hFFFF_FFFC,0,32'h40,32'h4444_4444);
        tbl[29] = mk(0,0,32'h0,1,0,32'h0,1,            1,32'hFFFF_FFFC,0,32'h40,32'h4444_4444);
        tbl[30] = mk(0,0,32'h0,1,1,32'h6666_6666,1,    0,32'hFFFF_FFFC,0,32'h40,32'h4444_4444);
        tbl[31] = mk(0,0,32'h0,1,0,32'h0,1,            0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'h6666_6666);
        tbl[32] = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h0,0,32'hFFFF_FFFC,32'h6666_6666);
        tbl[33] = mk(0,1,32'h300,1,1,32'h7777_7777,1,  0,32'h0,0,32'hFFFF_FFFC,32'h6666_6666);
        tbl[34] = mk(0,0,32'h0,1,0,32'h0,1,            1,32'h300,0,32'hFFFF_FFFC,32'h6666_6666);
        tbl[35] = mk(1,1,32'h500,1,0,32'h0,1,          0,32'h300,0,32'hFFFF_FFFC,32'h6666_6666);
        tbl[36] = mk(0,0,32'h0,0,0,32'h0,1,            1,32'h0,0,32'h0,NOP);

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        id_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            rst            = tbl[i].rst;
            redirect_valid = tbl[i].rdv;
            redirect_pc    = tbl[i].rdpc;
            imem_req_ready = tbl[i].rq_rdy;
            imem_rsp_valid = tbl[i].rsp_v;
            imem_rsp_data  = tbl[i].rsp_d;
            id_ready       = tbl[i].id_rdy;
            #1;
            chk("req_valid", i, {31'b0, imem_req_valid}, {31'b0, tbl[i].e_req_v});
            chk("req_addr",  i, imem_req_addr, tbl[i].e_addr);
            chk("id_valid",  i, {31'b0, id_valid}, {31'b0, tbl[i].e_idv});
            chk("id_pc",     i, id_pc, tbl[i].e_idpc);
            chk("id_pc_plus4", i, id_pc_plus4, tbl[i].e_idpc + 32'd4);
            chk("id_instr",  i, id_instr, tbl[i].e_instr);
        end

        // Free-running memory that answers every accepted request one cycle later.
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; id_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pending = 1'b0; pend_data = '0; nseen = 0;
        for (int c = 0; c < 40 && nseen < 3; c++) begin
            imem_rsp_valid = pending;
            imem_rsp_data  = pend_data;
            #1;
            pending   = imem_req_valid && imem_req_ready;
            pend_data = imem_req_addr ^ 32'hA5A5_0000;
            if (id_valid) begin
                chk("seq_cycle", nseen, c, 2 + 3 * nseen);
                chk("seq_id_pc", nseen, id_pc, 32'(4 * nseen));
                chk("seq_plus4", nseen, id_pc_plus4, 32'(4 * nseen + 4));
                chk("seq_instr", nseen, id_instr, 32'(4 * nseen) ^ 32'hA5A5_0000);
                nseen++;
            end
            @(negedge clk);
        end
        chk("seq_count", 0, nseen, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
